// File: rtl/prbs_word_source.sv
// prbs_word_source: framed 32-bit Fibonacci PRBS bit source with valid/ready
// handshake, feeding a serial encoder input port.
//
// Optional feature macro: PRBS_ERR_INJECT_EN (adds err_inject / err_count).
//
// Ports:
//   clk_in         sole clock, rising edge
//   rst            asynchronous active-low reset
//   start          begin a run (pulse)
//   abort          stop the run after the current cycle
//   data_in_ready  downstream can accept a bit
//   err_inject     (macro only) invert the next newly presented bit
//   err_count      (macro only) number of inverted bits transferred
//   data_out       serial PRBS bit, MSB-first
//   data_valid     data_out is valid
//   word_done      one-cycle pulse after a word's last bit transfers
//   busy           high while sending or in an inter-word gap
//   run_done       high once NUM_WORDS words have been sent
//   words_sent     words completed in the current run
module prbs_word_source #(
    parameter int unsigned       WORD_W     = 32,
    parameter int unsigned       NUM_WORDS  = 20,
    parameter int unsigned       GAP_CYCLES = 0,
    parameter logic [WORD_W-1:0] SEED       = 32'hB9DA8A28
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        data_in_ready,
`ifdef PRBS_ERR_INJECT_EN
    input  logic        err_inject,
    output logic [15:0] err_count,
`endif
    output logic        data_out,
    output logic        data_valid,
    output logic        word_done,
    output logic        busy,
    output logic        run_done,
    output logic [15:0] words_sent
);

    localparam int unsigned CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned CNT_LAST = WORD_W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]       words_q, words_d;
    logic              word_done_q, word_done_d;
    logic              valid_q, valid_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              run_done_q, run_done_d;
    logic              xfer;
    logic              fb;
    logic              start_go;
    logic              last_bit;
    logic              inv_d;

    // Next-state, LFSR and counter logic
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        words_d     = words_q;
        word_done_d = 1'b0;
        xfer        = (state_q == S_SEND) && data_in_ready;
        fb          = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
        start_go    = start && !abort;
        last_bit    = (bit_cnt_q == CNT_W'(CNT_LAST));

        if (xfer) begin
            lfsr_d    = {lfsr_q[WORD_W-2:0], fb};
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    state_d   = S_SEND;
                    lfsr_d    = SEED;
                    words_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            S_SEND: begin
                if (xfer && last_bit) begin
                    word_done_d = 1'b1;
                    words_d     = words_q + 16'd1;
                    if ((NUM_WORDS != 0) && (words_d == 16'(NUM_WORDS))) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES != 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end
                // Abort overrides any word-end transition; the transfer itself still counts.
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                // Restart without reseeding: the stream continues.
                if (start_go) begin
                    state_d   = S_SEND;
                    words_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d    = (state_d == S_SEND);
        busy_d     = (state_d == S_SEND) || (state_d == S_GAP);
        run_done_d = (state_d == S_DONE);
    end

    // Output bit is forced low whenever it is not valid
    assign dout_d = valid_d & (lfsr_d[WORD_W-1] ^ inv_d);

`ifdef PRBS_ERR_INJECT_EN
    logic        arm_q, arm_d;
    logic        inv_q;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Inversion is latched only when a new bit is presented, so a stalled bit never changes
    always_comb begin
        arm_d     = arm_q | err_inject;
        inv_d     = inv_q;
        err_cnt_d = err_cnt_q;
        if (xfer && inv_q) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if ((state_d == S_SEND) && (xfer || (state_q != S_SEND))) begin
            inv_d = arm_q | err_inject;
            arm_d = 1'b0;
        end else if (state_d != S_SEND) begin
            inv_d = 1'b0;
            arm_d = arm_q | err_inject | (inv_q & ~xfer);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            arm_q     <= 1'b0;
            inv_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            arm_q     <= arm_d;
            inv_q     <= inv_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign inv_d = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            words_q     <= '0;
            word_done_q <= 1'b0;
            valid_q     <= 1'b0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            words_q     <= words_d;
            word_done_q <= word_done_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            run_done_q  <= run_done_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign word_done  = word_done_q;
    assign busy       = busy_q;
    assign run_done   = run_done_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_prbs_word_source.sv
// Bench for prbs_word_source: stream-index reference model checked every cycle,
// plus directed scenarios (seed word, restart, abort, backpressure, reset, gaps).
module tb_prbs_word_source;

    localparam int          NW      = 20;
    localparam logic [31:0] SEED    = 32'hB9DA8A28;
    localparam int          REF_LEN = 2048;

    logic        clk;
    logic        rst;
    logic        start, abort, ready;
    logic        data_out, data_valid, word_done, busy, run_done;
    logic [15:0] words_sent;
    logic        start_g, ready_g;
    logic        data_out_g, data_valid_g, word_done_g, busy_g, run_done_g;
    logic [15:0] words_sent_g;
`ifdef PRBS_ERR_INJECT_EN
    logic        err_inject, err_inject_g;
    logic [15:0] err_count, err_count_g;
`endif

    prbs_word_source dut (
        .clk_in        (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .data_in_ready (ready),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject    (err_inject),
        .err_count     (err_count),
`endif
        .data_out      (data_out),
        .data_valid    (data_valid),
        .word_done     (word_done),
        .busy          (busy),
        .run_done      (run_done),
        .words_sent    (words_sent)
    );

    prbs_word_source #(.NUM_WORDS(2), .GAP_CYCLES(3)) dut_g (
        .clk_in        (clk),
        .rst           (rst),
        .start         (start_g),
        .abort         (1'b0),
        .data_in_ready (ready_g),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject    (err_inject_g),
        .err_count     (err_count_g),
`endif
        .data_out      (data_out_g),
        .data_valid    (data_valid_g),
        .word_done     (word_done_g),
        .busy          (busy_g),
        .run_done      (run_done_g),
        .words_sent    (words_sent_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_err, n_checks;
    logic        refb [REF_LEN];
    // model state: stream position, bit within word, run status
    int          m_ptr, m_bit, m_words, m_inv, m_errs;
    logic        m_run, m_done, m_wd, m_pend;
    logic        p_stall, p_bit;
    logic [31:0] obs, first_word;
    int          wd_cnt;
    int          g_n, g_low, g_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, advance the model with the inputs about to be sampled.
    task automatic step();
        logic eb;
        logic was_run;
        logic xf;
        @(negedge clk);
        if (!rst) begin
            chk("rst_valid", 32'(data_valid), 32'd0);
            chk("rst_dout", 32'(data_out), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_run_done", 32'(run_done), 32'd0);
            chk("rst_word_done", 32'(word_done), 32'd0);
            chk("rst_words", 32'(words_sent), 32'd0);
`ifdef PRBS_ERR_INJECT_EN
            chk("rst_err_count", 32'(err_count), 32'd0);
`endif
            m_run = 1'b0; m_done = 1'b0; m_wd = 1'b0; m_pend = 1'b0;
            m_ptr = 0; m_bit = 0; m_words = 0; m_inv = -1; m_errs = 0;
            p_stall = 1'b0;
        end else begin
            eb = m_run ? (refb[m_ptr] ^ (m_ptr == m_inv)) : 1'b0;
            chk("valid", 32'(data_valid), 32'(m_run));
            chk("busy", 32'(busy), 32'(m_run));
            chk("run_done", 32'(run_done), 32'(m_done));
            chk("word_done", 32'(word_done), 32'(m_wd));
            chk("words_sent", 32'(words_sent), 32'(m_words[15:0]));
            chk("data_out", 32'(data_out), 32'(eb));
            if (p_stall) begin
                chk("stall_valid", 32'(data_valid), 32'd1);
                chk("stall_hold", 32'(data_out), 32'(p_bit));
            end
`ifdef PRBS_ERR_INJECT_EN
            chk("err_count", 32'(err_count), 32'(m_errs[15:0]));
`endif
            p_stall = data_valid && !ready;
            p_bit   = data_out;
            was_run = m_run;
            xf      = m_run && ready;
            m_wd    = 1'b0;
            if (xf) begin
                if (m_ptr == m_inv) m_errs++;
                obs = {obs[30:0], data_out};
                m_ptr++;
                m_bit++;
                if (m_bit == 32) begin
                    m_bit = 0;
                    m_words++;
                    m_wd = 1'b1;
                    wd_cnt++;
                    if (m_words == 1) first_word = obs;
                    if (m_words == NW) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
`ifdef PRBS_ERR_INJECT_EN
            if (err_inject) m_pend = 1'b1;
`endif
            if (xf && m_run && m_pend) begin
                m_inv  = m_ptr;
                m_pend = 1'b0;
            end
            if (abort && was_run) begin
                m_run  = 1'b0;
                m_done = 1'b0;
            end else if (start && !abort && !was_run) begin
                if (!m_done) m_ptr = 0;
                m_inv   = m_pend ? m_ptr : -1;
                m_pend  = 1'b0;
                m_words = 0;
                m_bit   = 0;
                m_run   = 1'b1;
                m_done  = 1'b0;
            end

            // second instance: stream and gap accounting
            if (data_valid_g && ready_g) begin
                chk("gap_inst_data", 32'(data_out_g), 32'(refb[g_n]));
                g_n++;
            end else if (g_n > 0 && g_n < 64 && !data_valid_g) begin
                g_low++;
                chk("gap_inst_busy", 32'(busy_g), 32'd1);
            end
            if (word_done_g) g_wd++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] l;
        logic [31:0] w;
        n_err = 0; n_checks = 0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
        start_g = 1'b0; ready_g = 1'b1;
`ifdef PRBS_ERR_INJECT_EN
        err_inject = 1'b0; err_inject_g = 1'b0;
`endif
        m_run = 1'b0; m_done = 1'b0; m_wd = 1'b0; m_pend = 1'b0;
        m_ptr = 0; m_bit = 0; m_words = 0; m_inv = -1; m_errs = 0;
        p_stall = 1'b0; p_bit = 1'b0; obs = '0; first_word = '0; wd_cnt = 0;
        g_n = 0; g_low = 0; g_wd = 0;

        // reference bitstream straight from the polynomial
        l = SEED;
        for (int i = 0; i < REF_LEN; i++) begin
            refb[i] = l[31];
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], refb[i]};
        chk("ref_word0", w, 32'hB9DA8A28);
        chk("ref_bit32", 32'(refb[32]), 32'd1);
        chk("ref_bit33", 32'(refb[33]), 32'd0);

        // reset state
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // seed word and full 20-word run, ready high
        first_word = '0; wd_cnt = 0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 1000 && !run_done; i++) step();
        step();
        chk("runA_done", 32'(run_done), 32'd1);
        chk("runA_words", 32'(words_sent), 32'd20);
        chk("runA_first_word", first_word, 32'hB9DA8A28);
        chk("runA_word_done_count", 32'(wd_cnt), 32'd20);
        repeat (5) step();
        chk("runA_idle_valid", 32'(data_valid), 32'd0);

        // restart from DONE, then abort at bit 10 of word 2
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 200 && !(m_words == 1 && m_bit == 10); i++) step();
        chk("pre_abort_words", 32'(words_sent), 32'd1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_valid", 32'(data_valid), 32'd0);
        chk("abort_words", 32'(words_sent), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        step();

        // start and abort together while sending
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        chk("start_abort_valid", 32'(data_valid), 32'd0);
        chk("start_abort_busy", 32'(busy), 32'd0);
        step();

        // random backpressure, full run
        first_word = '0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5000 && !run_done; i++) begin
            ready = 1'($urandom_range(0, 1));
            step();
        end
        ready = 1'b1;
        step();
        chk("bp_done", 32'(run_done), 32'd1);
        chk("bp_words", 32'(words_sent), 32'd20);
        chk("bp_first_word", first_word, 32'hB9DA8A28);

        // reset mid-word, then replay from seed
        start = 1'b1; step(); start = 1'b0;
        repeat (45) step();
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_dout", 32'(data_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_words", 32'(words_sent), 32'd0);
        step();
        rst = 1'b1; step();
        first_word = '0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 100 && words_sent != 16'd1; i++) step();
        chk("midrst_replay_word", first_word, 32'hB9DA8A28);

`ifdef PRBS_ERR_INJECT_EN
        // single injection: bit 4 presented when pulsed, so bit 5 is inverted
        rst = 1'b0; step(); rst = 1'b1; step();
        first_word = '0;
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        err_inject = 1'b1; step(); err_inject = 1'b0;
        for (int i = 0; i < 100 && words_sent != 16'd1; i++) step();
        chk("inj_word", first_word, 32'hBDDA8A28);
        chk("inj_count", 32'(err_count), 32'd1);

        // two pulses during a stall on bit 3 merge into one inversion of bit 4
        rst = 1'b0; step(); rst = 1'b1; step();
        first_word = '0;
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        ready = 1'b0;
        err_inject = 1'b1; step(); err_inject = 1'b0; step();
        err_inject = 1'b1; step(); err_inject = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 100 && words_sent != 16'd1; i++) step();
        chk("inj2_word", first_word, 32'hB1DA8A28);
        chk("inj2_count", 32'(err_count), 32'd1);
`endif

        // gap instance: 2 words, 3 idle cycles between them
        g_n = 0; g_low = 0; g_wd = 0;
        start_g = 1'b1; step(); start_g = 1'b0;
        for (int i = 0; i < 400 && !run_done_g; i++) step();
        step();
        chk("gap_transfers", 32'(g_n), 32'd64);
        chk("gap_low_cycles", 32'(g_low), 32'd3);
        chk("gap_word_done", 32'(g_wd), 32'd2);
        chk("gap_words", 32'(words_sent_g), 32'd2);
        chk("gap_run_done", 32'(run_done_g), 32'd1);
        repeat (3) step();
        chk("gap_idle_valid", 32'(data_valid_g), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs_word_source.md
# prbs_word_source

Serial test-pattern source that sits directly upstream of the Hamming encoder's input port. Emits a maximal-length 32-bit PRBS bitstream MSB-first, framed into words, with a valid/ready handshake matching the encoder's `data_in`/`data_valid`/`data_in_ready` contract. Runs in the encoder input clock domain and replaces hand-written word lists in system benches.

## Interface
- `WORD_W`, 32: bits per word; also the LFSR width.
- `NUM_WORDS`, 20: words per run; 0 means continuous.
- `GAP_CYCLES`, 0: idle cycles with `data_valid` low between words.
- `SEED`, 32'hB9DA8A28: LFSR load value; must be nonzero.

Ports:
- `clk_in`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; one-cycle pulse.
- `abort`  in  1  stop the run after the current cycle.
- `data_in_ready`  in  1  encoder can accept a bit.
- `data_out`  out  1  serial PRBS bit; connects to encoder `data_in`.
- `data_valid`  out  1  `data_out` is valid.
- `word_done`  out  1  one-cycle pulse when a word's last bit transfers.
- `busy`  out  1  high in SEND or GAP.
- `run_done`  out  1  high in DONE.
- `words_sent`  out  16  count of words completed in the current run.

## Operation
- **LFSR.** Fibonacci, 32 bits. `fb = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]`. On each transfer it shifts as `lfsr <= {lfsr[30:0], fb}`.
- **Output bit.** `data_out = lfsr[31]`. The first 32 bits after a seed load therefore equal `SEED`, MSB-first.
- **Transfer.** A bit transfers on a rising edge where `data_valid && data_in_ready`. Only a transfer advances the LFSR and `bit_cnt` (5 bits, counts 0..WORD_W-1).
- **States.** IDLE, SEND, GAP, DONE.
  - IDLE to SEND: on `start`. The LFSR is loaded with `SEED`; `words_sent` and `bit_cnt` clear.
  - SEND: when a transfer happens with `bit_cnt == WORD_W-1`:
    - `word_done` pulses and `words_sent` increments;
    - if `NUM_WORDS != 0` and the incremented count equals `NUM_WORDS`, go to DONE;
    - otherwise go to GAP, or stay in SEND when `GAP_CYCLES == 0`.
  - GAP: counts `GAP_CYCLES` cycles with `data_valid` low, then returns to SEND.
  - DONE: holds. `start` re-enters SEND with `words_sent` cleared. The LFSR is not reseeded, so the stream continues.
- **Abort.** In SEND or GAP, `abort` moves the FSM to IDLE on the next edge. The LFSR and `words_sent` are kept; a partial word is discarded. A transfer on the same edge still counts.
- **Ignored inputs.** `start` is ignored in SEND and GAP. If `start` and `abort` are high together, `abort` wins.
- **Wrap.** `words_sent` wraps 16'hFFFF to 0 in continuous mode.

## Timing
- **Reset values.** While `rst` is low, all outputs are 0, the LFSR holds `SEED`, and the FSM is in IDLE. Reset takes effect immediately, mid-word included.
- **Start latency.** `start` sampled high at edge N makes `data_valid` high and `data_out = SEED[31]` from edge N+1.
- **Output timing.** All outputs are registered; no input-to-output combinational path.
- **Stalls.** While `data_valid` is high and `data_in_ready` is low, `data_out` and `data_valid` hold stable.
- **Throughput.** Back-to-back words with `GAP_CYCLES == 0` and ready always high: 32 consecutive valid cycles per word, no bubble.
- **Gap length.** With `GAP_CYCLES = G`, `data_valid` is low for exactly G cycles between words.
- **End of run.** `word_done` and the `words_sent` update coincide with the edge following the last transfer. `run_done` rises on the same edge.

## Configuration
- **`PRBS_ERR_INJECT_EN` defined.** Adds input port `err_inject` (1 bit) and output `err_count` (16 bits, reset 0).
  - An `err_inject` pulse arms a flag. The next transferred bit goes out inverted; the LFSR is unaffected.
  - The flag clears on that transfer and `err_count` increments.
  - Pulses while the flag is already armed merge into one injection.
- **Undefined.** Neither port exists, and `data_out` is always `lfsr[31]`.

## Test plan
- **Seed word.** Default params, ready tied high, `start` pulse. Required:
  - the first 32 bits are 32'hB9DA8A28 MSB-first;
  - `word_done` pulses after bit 32;
  - after 20 words, `run_done = 1` and `words_sent = 20`;
  - `data_valid` stays low afterwards.
- **Backpressure.** Toggle ready at random. Required:
  - the bitstream is identical to the ready-high run;
  - `data_out` never changes while valid is high and ready is low.
- **Gaps.** `GAP_CYCLES = 3`, `NUM_WORDS = 2`. Required: exactly 3 low-valid cycles between words; 64 transfers total.
- **Abort and reset mid-word.**
  - `abort` at bit 10 of word 2: IDLE next cycle, `words_sent = 1`.
  - `rst` low mid-word: all outputs 0 immediately; the next `start` replays from `SEED`.
- **Restart and simultaneous inputs.**
  - `start` in DONE: the stream continues from the LFSR state, `words_sent` restarts at 0.
  - `start` and `abort` together in SEND: IDLE.
- **Error injection (macro defined).** Pulse `err_inject` before bit 5 of word 1. Required:
  - only bit 5 differs from the reference stream;
  - `err_count = 1`;
  - two pulses before the same transfer still give `err_count = 1`.
